// File: rtl/mux_2x1_pkg.sv
// Shared constants for the mux_2x1 leaf selector: default sizes and select encodings.
package mux_2x1_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/mux_2x1_sat_counter.sv
// Saturating up-counter: +1 per cycle while inc is high, holds at all-ones, sync reset.
// Latency: count visible 1 cycle after inc. No backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/mux_2x1.sv
// 2:1 lane selector with combinational dout plus a registered copy, valid and select-change count.
// Latency: dout 0 cycles, dout_q/out_valid/sel_chg_cnt 1 cycle. No backpressure; MUX_2X1_PARITY_EN adds dout_par.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] din,
  input  logic               sel,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   dout_q,
  output logic               out_valid,
  output logic [CNT_W-1:0]   sel_chg_cnt
`ifdef MUX_2X1_PARITY_EN
  ,
  output logic               dout_par
`endif
);

  logic [WIDTH-1:0] lane0;
  logic [WIDTH-1:0] lane1;
  logic             sel_prev;

  assign lane0 = din[WIDTH-1:0];
  assign lane1 = din[2*WIDTH-1:WIDTH];

  // Plain ternary so an unknown select propagates with standard merge semantics.
  assign dout = sel ? lane1 : lane0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      out_valid <= 1'b0;
      sel_prev  <= LANE0;
    end else begin
      sel_prev  <= sel;
      out_valid <= in_valid;
      if (in_valid) begin
        dout_q <= dout;
      end
    end
  end

`ifdef MUX_2X1_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_par <= 1'b0;
    end else if (in_valid) begin
      dout_par <= ^dout;
    end
  end
`endif

  sat_counter #(
    .W(CNT_W)
  ) u_sel_cnt (
    .clk(clk),
    .rst(rst),
    .inc(sel != sel_prev),
    .cnt(sel_chg_cnt)
  );

endmodule

// File: tb/tb_mux_2x1.sv
// Directed self-checking bench for mux_2x1: WIDTH=1 and WIDTH=8 instances plus a CNT_W=3 instance.
module tb_mux_2x1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  din1 = 2'b10;
  logic [15:0] din8 = {8'hA5, 8'h3C};

  logic        dout1, dout_q1, ov1;
  logic [7:0]  cnt1;
  logic [7:0]  dout8, dout_q8;
  logic        ov8;
  logic [7:0]  cnt8;
  logic [7:0]  dout_c3, dout_q_c3;
  logic        ov_c3;
  logic [2:0]  cnt_c3;
`ifdef MUX_2X1_PARITY_EN
  logic        par1, par8, par_c3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_2x1 #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .din(din1), .sel(sel), .in_valid(in_valid),
    .dout(dout1), .dout_q(dout_q1), .out_valid(ov1), .sel_chg_cnt(cnt1)
`ifdef MUX_2X1_PARITY_EN
    , .dout_par(par1)
`endif
  );

  mux_2x1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .din(din8), .sel(sel), .in_valid(in_valid),
    .dout(dout8), .dout_q(dout_q8), .out_valid(ov8), .sel_chg_cnt(cnt8)
`ifdef MUX_2X1_PARITY_EN
    , .dout_par(par8)
`endif
  );

  mux_2x1 #(.WIDTH(8), .CNT_W(3)) u_c3 (
    .clk(clk), .rst(rst), .din(din8), .sel(sel), .in_valid(in_valid),
    .dout(dout_c3), .dout_q(dout_q_c3), .out_valid(ov_c3), .sel_chg_cnt(cnt_c3)
`ifdef MUX_2X1_PARITY_EN
    , .dout_par(par_c3)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    din1 = 2'b10;
    sel  = 1'b0;
    #1;
    checks++;
    if (dout1 !== 1'b0) begin errors++; $display("FAIL comb_sel0 dout=%0b want 0", dout1); end
    #4 sel = 1'b1;
    #1;
    checks++;
    if (dout1 !== 1'b1) begin errors++; $display("FAIL comb_sel1 dout=%0b want 1", dout1); end
    checks++;
    if (dout8 !== 8'hA5) begin errors++; $display("FAIL comb8_sel1 dout=%h want a5", dout8); end
    #4 sel = 1'b0;
    #1;
    checks++;
    if (dout1 !== 1'b0) begin errors++; $display("FAIL comb_back0 dout=%0b want 0", dout1); end
    checks++;
    if (dout8 !== 8'h3C) begin errors++; $display("FAIL comb8_sel0 dout=%h want 3c", dout8); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dout_q8 !== 8'h00 || ov8 !== 1'b0 || cnt8 !== 8'd0) begin
        errors++;
        $display("FAIL reset_cyc%0d q=%h v=%0b cnt=%0d want 00/0/0", i, dout_q8, ov8, cnt8);
      end
      checks++;
      if (dout_q1 !== 1'b0 || ov1 !== 1'b0 || cnt_c3 !== 3'd0) begin
        errors++;
        $display("FAIL reset_other%0d q1=%0b v1=%0b cnt3=%0d want 0/0/0", i, dout_q1, ov1, cnt_c3);
      end
    end
  endtask

  task automatic test_capture();
    // Still sel=1, in_valid=1 from reset; first cycle compares against sel_prev=0.
    din8 = {8'hA5, 8'h3C};
    rst  = 1'b0;
    tick();
    checks++;
    if (dout_q8 !== 8'hA5 || ov8 !== 1'b1) begin
      errors++; $display("FAIL capture q=%h v=%0b want a5/1", dout_q8, ov8);
    end
    checks++;
    if (dout_q1 !== 1'b1) begin errors++; $display("FAIL capture_w1 q=%0b want 1", dout_q1); end
    checks++;
    if (cnt8 !== 8'd1) begin errors++; $display("FAIL first_after_reset cnt=%0d want 1", cnt8); end
    in_valid = 1'b0;
    sel      = 1'b0;
    tick();
    checks++;
    if (dout_q8 !== 8'hA5 || ov8 !== 1'b0) begin
      errors++; $display("FAIL hold q=%h v=%0b want a5/0", dout_q8, ov8);
    end
    checks++;
    if (cnt8 !== 8'd2) begin errors++; $display("FAIL hold_cnt cnt=%0d want 2", cnt8); end
  endtask

  task automatic test_toggle();
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      sel = ~sel;
      if (i == 7) begin
        checks++;
        if (cnt8 !== 8'd7 || cnt_c3 !== 3'd7) begin
          errors++; $display("FAIL toggle7 cnt8=%0d cnt3=%0d want 7/7", cnt8, cnt_c3);
        end
      end
    end
    checks++;
    if (cnt8 !== 8'd10) begin errors++; $display("FAIL toggle10 cnt8=%0d want 10", cnt8); end
    checks++;
    if (cnt_c3 !== 3'd7) begin errors++; $display("FAIL sat3 cnt3=%0d want 7", cnt_c3); end
    // Last sampled sel was 0; keep it there so no change is seen.
    sel = 1'b0;
    tick();
    checks++;
    if (cnt8 !== 8'd10) begin errors++; $display("FAIL steady cnt8=%0d want 10", cnt8); end
  endtask

  task automatic test_saturate8();
    rst = 1'b1; sel = 1'b0;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
      sel = ~sel;
    end
    checks++;
    if (cnt8 !== 8'hFF) begin errors++; $display("FAIL sat8 cnt8=%0d want 255", cnt8); end
  endtask

  task automatic test_midreset();
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1;
    sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sel = ~sel;
    end
    // Sampled sels were 1,0,1,0,1.
    checks++;
    if (cnt8 !== 8'd5 || ov8 !== 1'b1 || dout_q8 !== 8'hA5) begin
      errors++; $display("FAIL pre_midreset cnt=%0d v=%0b q=%h want 5/1/a5", cnt8, ov8, dout_q8);
    end
    rst = 1'b1;
    sel = 1'b0;
    tick();
    checks++;
    if (cnt8 !== 8'd0 || ov8 !== 1'b0 || dout_q8 !== 8'h00) begin
      errors++; $display("FAIL midreset cnt=%0d v=%0b q=%h want 0/0/00", cnt8, ov8, dout_q8);
    end
    checks++;
    if (dout8 !== 8'h3C) begin errors++; $display("FAIL midreset_comb0 dout=%h want 3c", dout8); end
    sel = 1'b1;
    #1;
    checks++;
    if (dout8 !== 8'hA5) begin errors++; $display("FAIL midreset_comb1 dout=%h want a5", dout8); end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

`ifdef MUX_2X1_PARITY_EN
  task automatic test_parity();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din8 = {8'h07, 8'h03};
    sel = 1'b1; in_valid = 1'b1;
    tick();
    checks++;
    if (par8 !== 1'b1) begin errors++; $display("FAIL parity_07 par=%0b want 1", par8); end
    sel = 1'b0;
    tick();
    checks++;
    if (par8 !== 1'b0) begin errors++; $display("FAIL parity_03 par=%0b want 0", par8); end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_comb();
    test_reset();
    test_capture();
    test_toggle();
    test_saturate8();
    test_midreset();
`ifdef MUX_2X1_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
